// File: rtl/ins_enc_pkg.sv
// Shared definitions for the RV32 instruction encoder: format codes, opcode
// constants and the bundled field set handed to the packer.
package ins_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  func7;
        logic [11:0] imm12;
        logic [19:0] imm20;
    } fields_t;

endpackage

// File: rtl/ins_enc_if.sv
// Field-set input handshake and encoded-word output handshake of ins_enc.
interface ins_enc_if;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ins;
    logic [31:0] addr;
    logic        err;

    modport master (
        output clear, in_valid, fmt, opcode, rd, func3, rs1, rs2, func7,
               imm12, imm20, out_ready,
        input  in_ready, out_valid, ins, addr, err
    );

    modport slave (
        input  clear, in_valid, fmt, opcode, rd, func3, rs1, rs2, func7,
               imm12, imm20, out_ready,
        output in_ready, out_valid, ins, addr, err
    );
endinterface

// File: rtl/ins_pack.sv
// Combinational RV32 packer: field set plus format code -> 32-bit word.
// Codes outside R..J raise illegal and yield a zero word.
import ins_enc_pkg::*;

module ins_pack (
    input  logic [2:0]  fmt,
    input  fields_t     fields,
    output logic [31:0] word,
    output logic        illegal
);
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: word = {fields.func7, fields.rs2, fields.rs1, fields.func3,
                           fields.rd, fields.opcode};
            FMT_I: word = {fields.imm12, fields.rs1, fields.func3, fields.rd,
                           fields.opcode};
            FMT_S: word = {fields.imm12[11:5], fields.rs2, fields.rs1,
                           fields.func3, fields.imm12[4:0], fields.opcode};
            // imm12 carries imm[12:1] here, so imm[12] sits at imm12[11]
            FMT_B: word = {fields.imm12[11], fields.imm12[9:4], fields.rs2,
                           fields.rs1, fields.func3, fields.imm12[3:0],
                           fields.imm12[10], fields.opcode};
            FMT_U: word = {fields.imm20, fields.rd, fields.opcode};
            FMT_J: word = {fields.imm20[19], fields.imm20[9:0], fields.imm20[10],
                           fields.imm20[18:11], fields.rd, fields.opcode};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/ins_enc.sv
// Single-entry registered encoder stage: accepts a field set, emits the packed
// word tagged with a running byte address, and flags illegal formats.
import ins_enc_pkg::*;

module ins_enc #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic      clk,
    input logic      rst_n,
    ins_enc_if.slave bus
);
    fields_t     fields;
    logic [31:0] word;
    logic        illegal;
    logic        accept;
    logic [31:0] counter;
    logic        out_valid_q;
    logic [31:0] ins_q;
    logic [31:0] addr_q;
    logic        err_q;

    assign fields = '{opcode: bus.opcode, rd: bus.rd, func3: bus.func3,
                      rs1: bus.rs1, rs2: bus.rs2, func7: bus.func7,
                      imm12: bus.imm12, imm20: bus.imm20};

    ins_pack u_pack (
        .fmt    (bus.fmt),
        .fields (fields),
        .word   (word),
        .illegal(illegal)
    );

    // clear blocks acceptance so nothing slips in while the stage restarts
    assign bus.in_ready = !bus.clear && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ins_q       <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            counter     <= BASE_ADDR;
        end else if (bus.clear) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            counter     <= BASE_ADDR;
        end else begin
            if (accept && !illegal) begin
                out_valid_q <= 1'b1;
                ins_q       <= word;
                addr_q      <= counter;
                counter     <= counter + 32'd4;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ins       = ins_q;
    assign bus.addr      = addr_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ins_enc.sv
// Randomised scoreboard bench for ins_enc: drivers push expected words, a
// monitor pops and compares each word the DUT hands over.
module tb_ins_enc;
    import ins_enc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [11:0] imm12;
        logic [19:0] imm20;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] ins;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          fails = 0;
    int          bp_mode = 0;
    exp_t        q[$];
    logic [31:0] exp_addr = BASE;
    logic        exp_err = 1'b0;
    bit          held = 1'b0;
    logic [31:0] h_ins;
    logic [31:0] h_addr;

    ins_enc_if bus();

    ins_enc #(.BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Reference encoder built from the architectural immediate value.
    function automatic logic [32:0] ref_enc(input stim_t s);
        logic [12:0] b;
        logic [20:0] j;
        b = {s.imm12, 1'b0};
        j = {s.imm20, 1'b0};
        case (s.fmt)
            3'd0: return {1'b1, s.f7, s.rs2, s.rs1, s.f3, s.rd, s.op};
            3'd1: return {1'b1, s.imm12, s.rs1, s.f3, s.rd, s.op};
            3'd2: return {1'b1, s.imm12[11:5], s.rs2, s.rs1, s.f3, s.imm12[4:0], s.op};
            3'd3: return {1'b1, b[12], b[10:5], s.rs2, s.rs1, s.f3, b[4:1], b[11], s.op};
            3'd4: return {1'b1, s.imm20, s.rd, s.op};
            3'd5: return {1'b1, j[20], j[10:1], j[11], j[19:12], s.rd, s.op};
            default: return 33'd0;
        endcase
    endfunction

    // Decoder: recover the fields the format uses and compare to what was sent.
    function automatic bit dec_ok(input logic [31:0] w, input stim_t s);
        bit ok;
        ok = (w[6:0] == s.op);
        case (s.fmt)
            3'd0: ok &= (w[11:7] == s.rd) && (w[14:12] == s.f3) && (w[19:15] == s.rs1)
                        && (w[24:20] == s.rs2) && (w[31:25] == s.f7);
            3'd1: ok &= (w[11:7] == s.rd) && (w[14:12] == s.f3) && (w[19:15] == s.rs1)
                        && (w[31:20] == s.imm12);
            3'd2: ok &= (w[14:12] == s.f3) && (w[19:15] == s.rs1) && (w[24:20] == s.rs2)
                        && ({w[31:25], w[11:7]} == s.imm12);
            3'd3: ok &= (w[14:12] == s.f3) && (w[19:15] == s.rs1) && (w[24:20] == s.rs2)
                        && ({w[31], w[7], w[30:25], w[11:8]} == s.imm12);
            3'd4: ok &= (w[11:7] == s.rd) && (w[31:12] == s.imm20);
            3'd5: ok &= (w[11:7] == s.rd) && ({w[31], w[19:12], w[20], w[30:21]} == s.imm20);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic stim_t mk(input int fmt, input int op, input int rd, input int f3,
                                 input int rs1, input int rs2, input int f7,
                                 input int imm12, input int imm20);
        stim_t s;
        s.fmt   = 3'(fmt);
        s.op    = 7'(op);
        s.rd    = 5'(rd);
        s.f3    = 3'(f3);
        s.rs1   = 5'(rs1);
        s.rs2   = 5'(rs2);
        s.f7    = 7'(f7);
        s.imm12 = 12'(imm12);
        s.imm20 = 20'(imm20);
        return s;
    endfunction

    function automatic stim_t rnd(input bit legal_only);
        stim_t s;
        s.fmt   = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
        s.op    = 7'($urandom);
        s.rd    = 5'($urandom);
        s.f3    = 3'($urandom);
        s.rs1   = 5'($urandom);
        s.rs2   = 5'($urandom);
        s.f7    = 7'($urandom);
        s.imm12 = 12'($urandom);
        s.imm20 = 20'($urandom);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.fmt    = s.fmt;
        bus.opcode = s.op;
        bus.rd     = s.rd;
        bus.func3  = s.f3;
        bus.rs1    = s.rs1;
        bus.rs2    = s.rs2;
        bus.func7  = s.f7;
        bus.imm12  = s.imm12;
        bus.imm20  = s.imm20;
    endtask

    // Present s until accepted; push the expected word on the accepting edge.
    task automatic send(input stim_t s, input bit use_k, input logic [31:0] k);
        logic [32:0] r;
        exp_t        e;
        int          n;
        @(negedge clk);
        apply(s);
        bus.in_valid = 1'b1;
        n = 0;
        #1;
        while (!bus.in_ready) begin
            if (n == 300) begin
                checks++;
                fails++;
                $display("FAIL accept_timeout: in_ready %0b after %0d cycles, required 1", bus.in_ready, n);
                bus.in_valid = 1'b0;
                return;
            end
            n++;
            @(negedge clk);
            #1;
        end
        r = ref_enc(s);
        if (r[32]) begin
            e.s    = s;
            e.ins  = use_k ? k : r[31:0];
            e.addr = exp_addr;
            q.push_back(e);
            exp_addr = exp_addr + 32'd4;
        end else begin
            exp_err = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words outstanding, required 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: sampled mid-low-phase, before the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n || bus.clear || !bus.out_valid) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_ins", bus.ins, h_ins);
                    check("hold_addr", bus.addr, h_addr);
                end
                if (!bus.out_ready) begin
                    check("in_ready_bp", 32'(bus.in_ready), 32'd0);
                    held   = 1'b1;
                    h_ins  = bus.ins;
                    h_addr = bus.addr;
                end else begin
                    held = 1'b0;
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_word: ins %h addr %h, required no word", bus.ins, bus.addr);
                    end else begin
                        e = q.pop_front();
                        check("ins", bus.ins, e.ins);
                        check("addr", bus.addr, e.addr);
                        check("roundtrip", 32'(dec_ok(bus.ins, e.s)), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ins", bus.ins, 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known encodings, one per format.
        send(mk(1, OP_IMM, 1, 0, 0, 0, 0, 5, 0), 1'b1, 32'h0050_0093);
        send(mk(0, OP_REG, 3, 0, 1, 2, 0, 0, 0), 1'b1, 32'h0020_81B3);
        send(mk(2, OP_STORE, 0, 2, 1, 2, 0, 8, 0), 1'b1, 32'h0020_A423);
        send(mk(4, OP_LUI, 5, 0, 0, 0, 0, 0, 'h12345), 1'b1, 32'h1234_52B7);
        send(mk(3, OP_BRANCH, 0, 0, 1, 2, 0, 4, 0), 1'b1, 32'h0020_8463);
        send(mk(5, OP_JAL, 1, 0, 0, 0, 0, 0, 'h400), 1'b1, 32'h0010_00EF);
        idle();
        drain();

        // Illegal format between two legal words, then clear.
        check("err_before", 32'(bus.err), 32'd0);
        send(rnd(1'b1), 1'b0, 32'd0);
        send(mk(7, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0);
        send(rnd(1'b1), 1'b0, 32'd0);
        idle();
        drain();
        check("err_set", 32'(bus.err), 32'(exp_err));
        bus.clear = 1'b1;
        apply(rnd(1'b1));
        bus.in_valid = 1'b1;
        #1;
        check("clear_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        exp_addr     = BASE;
        exp_err      = 1'b0;
        #1;
        check("err_cleared", 32'(bus.err), 32'd0);
        send(rnd(1'b1), 1'b0, 32'd0);
        idle();
        drain();

        // Backpressure: consumer stalls while the producer keeps offering.
        @(posedge clk);
        bp_mode = 2;
        fork
            begin
                send(rnd(1'b1), 1'b0, 32'd0);
                send(rnd(1'b1), 1'b0, 32'd0);
                send(rnd(1'b1), 1'b0, 32'd0);
                idle();
            end
            begin
                repeat (7) @(posedge clk);
                bp_mode = 0;
            end
        join
        drain();

        // Asynchronous reset while a word is held.
        @(posedge clk);
        bp_mode = 2;
        send(rnd(1'b1), 1'b0, 32'd0);
        idle();
        #2;
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_addr", bus.addr, 32'd0);
        check("mid_rst_ins", bus.ins, 32'd0);
        q.delete();
        exp_addr = BASE;
        exp_err  = 1'b0;
        @(posedge clk);
        bp_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(rnd(1'b1), 1'b0, 32'd0);
        idle();
        drain();

        // Random traffic with random backpressure and illegal formats.
        @(posedge clk);
        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(rnd(1'b0), 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        @(posedge clk);
        bp_mode = 0;
        drain();
        check("err_final", 32'(bus.err), 32'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
